fp16_mul_arbiter: RTL

//  Shares one FP16 multiply stage (16b sign/exp/mant operands; 16b product plus 20b temp mantissa) between NREQ requesters.
//  - Round-robin arbitration; one operand pair issued per cycle.
//  - Tracks in-flight ops with a fixed-latency tag pipe and routes results back through per-requester result buffers.
//  - Issues only when the destination buffer has guaranteed space (credit flow).
//  - Sits between MAC lanes and the multiply stage, ahead of the accumulate stage.

---
 rtl/fp16_mac_pkg.sv | 22 ++
 rtl/fp16_res_fifo.sv | 60 ++++++
 rtl/fp16_mul_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fp16_mac_pkg.sv
// Shared FP16 MAC definitions: field widths, requester id width and the
// in-flight tag record carried alongside each multiply.
package fp16_mac_pkg;

  localparam int FP16_W = 16;
  localparam int EXP_W  = 5;
  localparam int MANT_W = 10;
  localparam int TM_W   = 20;
  localparam logic [EXP_W-1:0] FP16_BIAS = 5'b01111;

  // Requester id width; covers up to four requesters.
  localparam int ID_W = 2;

  // One result buffer entry is {product, temp mantissa}.
  localparam int RES_W = FP16_W + TM_W;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/fp16_res_fifo.sv
// Per-requester result FIFO. The head is presented combinationally and reads
// as zero while empty. Pops on an empty FIFO are ignored; the caller guarantees
// that a write never lands on a full FIFO unless a pop happens in the same cycle.
module fp16_res_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             not_empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign not_empty = (r_count != '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign w_pop     = rd_en && not_empty;
  assign rd_data   = not_empty ? r_mem[r_rd_ptr] : '0;

  // Storage write; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_pop) r_rd_ptr <= f_next(r_rd_ptr);
      case ({wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fp16_mul_arbiter.sv
// Round-robin front end for a shared fixed-latency FP16 multiply stage.
// Each requester owns a credit counter covering in-flight plus buffered
// results, so an op is only issued when its result buffer is sure to have room.
// A tag pipe matching the multiply latency steers each product back to the
// buffer of the requester that issued it.
module fp16_mul_arbiter
  import fp16_mac_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int MUL_LAT   = 4,
  parameter int RES_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [FP16_W*NREQ-1:0] req_a,
  input  logic [FP16_W*NREQ-1:0] req_b,
  output logic [FP16_W-1:0]      mul_ai,
  output logic [FP16_W-1:0]      mul_bi,
  output logic                   mul_issue,
  input  logic [FP16_W-1:0]      mul_po,
  input  logic [TM_W-1:0]        mul_tm,
  output logic [NREQ-1:0]        res_valid,
  input  logic [NREQ-1:0]        res_ready,
  output logic [FP16_W*NREQ-1:0] res_p,
  output logic [TM_W*NREQ-1:0]   res_tm
);

  localparam int CRED_W = $clog2(RES_DEPTH + 1);

  logic [ID_W-1:0]   r_rr;
  logic [FP16_W-1:0] r_mul_ai;
  logic [FP16_W-1:0] r_mul_bi;
  logic              r_mul_issue;
  tag_t              r_tag [MUL_LAT];

  logic [NREQ-1:0]   w_elig;
  logic [NREQ-1:0]   w_grant_oh;
  logic [NREQ-1:0]   w_pop;
  logic [NREQ-1:0]   w_wr;
  logic [NREQ-1:0]   w_full;
  logic              w_grant_any;
  logic [ID_W-1:0]   w_grant_id;
  logic [FP16_W-1:0] w_sel_a;
  logic [FP16_W-1:0] w_sel_b;

  assign req_ready = w_grant_oh;
  assign mul_ai    = r_mul_ai;
  assign mul_bi    = r_mul_bi;
  assign mul_issue = r_mul_issue;

  // Round-robin search starting at the pointer, then operand select for the winner.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_grant_any && w_elig[(int'(r_rr) + k) % NREQ]) begin
        w_grant_any = 1'b1;
        w_grant_id  = ID_W'((int'(r_rr) + k) % NREQ);
      end
    end
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant_oh[k]) begin
        w_sel_a = req_a[k*FP16_W +: FP16_W];
        w_sel_b = req_b[k*FP16_W +: FP16_W];
      end
    end
  end

  // Pointer advance and operand issue register; operands hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr        <= '0;
      r_mul_ai    <= '0;
      r_mul_bi    <= '0;
      r_mul_issue <= 1'b0;
    end else begin
      r_mul_issue <= w_grant_any;
      if (w_grant_any) begin
        r_rr     <= (int'(w_grant_id) == NREQ - 1) ? '0 : w_grant_id + 1'b1;
        r_mul_ai <= w_sel_a;
        r_mul_bi <= w_sel_b;
      end
    end
  end

  // Tag pipe: stage 0 runs alongside the issue register, last stage marks the product edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < MUL_LAT; s++) r_tag[s] <= '0;
    end else begin
      r_tag[0] <= '{valid: w_grant_any, id: w_grant_id};
      for (int s = 1; s < MUL_LAT; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  // Grant is never one-hot violated.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_grant_onehot: assert ($onehot0(req_ready));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      logic [CRED_W-1:0] r_cred;
      logic [RES_W-1:0]  w_head;

      assign w_elig[gi]     = !rst && req_valid[gi] && (r_cred < CRED_W'(RES_DEPTH));
      assign w_grant_oh[gi] = w_grant_any && (w_grant_id == ID_W'(gi));
      assign w_pop[gi]      = res_valid[gi] && res_ready[gi];
      assign w_wr[gi]       = r_tag[MUL_LAT-1].valid && (r_tag[MUL_LAT-1].id == ID_W'(gi));

      // Credit: +1 per grant, -1 per pop, unchanged when both happen together.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cred <= '0;
        end else if (w_grant_oh[gi] && !w_pop[gi]) begin
          r_cred <= r_cred + 1'b1;
        end else if (!w_grant_oh[gi] && w_pop[gi]) begin
          r_cred <= r_cred - 1'b1;
        end
      end

      fp16_res_fifo #(
        .WIDTH (RES_W),
        .DEPTH (RES_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (w_wr[gi]),
        .wr_data   ({mul_po, mul_tm}),
        .rd_en     (res_ready[gi]),
        .rd_data   (w_head),
        .not_empty (res_valid[gi]),
        .full      (w_full[gi])
      );

      assign res_p[gi*FP16_W +: FP16_W] = w_head[RES_W-1 -: FP16_W];
      assign res_tm[gi*TM_W +: TM_W]    = w_head[TM_W-1:0];

      // Credit stays bounded and the buffer is never overrun.
      always_ff @(posedge clk) begin
        if (!rst) begin
          a_cred_bound: assert (r_cred <= CRED_W'(RES_DEPTH));
          a_no_overrun: assert (!(w_wr[gi] && w_full[gi] && !w_pop[gi]));
        end
      end
    end
  endgenerate

endmodule
